// File: rtl/aes_encryption_iter.sv
// Iterative AES encryption core: one round per clock from a latched round-key chain.
// Valid/ready on the plaintext side, valid/yumi on the ciphertext side.
module aes_encryption_iter #(
    parameter int num_rounds_p = 14
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          v_i,
    output logic                          ready_o,
    input  logic [127:0]                  plaintext_i,
    input  logic [(num_rounds_p+1)*128-1:0] key_chain_i,
    output logic                          v_o,
    output logic [127:0]                  ciphertext_o,
    input  logic                          yumi_i
);

    localparam int key_w = (num_rounds_p + 1) * 128;
    localparam int cnt_w = $clog2(num_rounds_p + 1);
    localparam logic [cnt_w-1:0] last_round = cnt_w'(num_rounds_p);

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_run  = 2'd1;
    localparam logic [1:0] st_done = 2'd2;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return sbox_table[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [1:0]        fsm_reg;
    logic [1:0]        fsm_next;
    logic [cnt_w-1:0]  round_cnt_reg;
    logic [127:0]      state_reg;
    logic [127:0]      ct_reg;
    logic [key_w-1:0]  key_reg;

    logic [127:0]      rk [num_rounds_p+1];
    logic [7:0]        sub_b   [16];
    logic [7:0]        shift_b [16];
    logic [7:0]        mix_b   [16];
    logic [127:0]      shift_w;
    logic [127:0]      mix_w;
    logic [127:0]      round_key;

    genvar gi;

    generate
        for (gi = 0; gi <= num_rounds_p; gi++) begin : g_rk
            assign rk[gi] = key_reg[key_w-1-128*gi -: 128];
        end

        // Bytes are column-major: byte gi sits at row gi%4, column gi/4.
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            assign sub_b[gi]   = sbox(state_reg[127-8*gi -: 8]);
            assign shift_b[gi] = sub_b[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
            assign shift_w[127-8*gi -: 8] = shift_b[gi];
            assign mix_w[127-8*gi -: 8]   = mix_b[gi];
        end

        for (gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = shift_b[4*gi];
            assign a1 = shift_b[4*gi+1];
            assign a2 = shift_b[4*gi+2];
            assign a3 = shift_b[4*gi+3];
            assign mix_b[4*gi]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mix_b[4*gi+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mix_b[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mix_b[4*gi+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    assign round_key = rk[round_cnt_reg];

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            st_idle: if (v_i)                          fsm_next = st_run;
            st_run:  if (round_cnt_reg == last_round)  fsm_next = st_done;
            st_done: if (yumi_i)                       fsm_next = st_idle;
            default:                                   fsm_next = st_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fsm_reg       <= st_idle;
            round_cnt_reg <= '0;
            state_reg     <= '0;
            ct_reg        <= '0;
            key_reg       <= '0;
        end else begin
            fsm_reg <= fsm_next;
            case (fsm_reg)
                st_idle: begin
                    if (v_i) begin
                        state_reg     <= plaintext_i ^ key_chain_i[key_w-1 -: 128];
                        key_reg       <= key_chain_i;
                        round_cnt_reg <= cnt_w'(1);
                    end
                end
                st_run: begin
                    if (round_cnt_reg == last_round) begin
                        ct_reg <= shift_w ^ round_key;
                    end else begin
                        state_reg     <= mix_w ^ round_key;
                        round_cnt_reg <= round_cnt_reg + cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o      = (fsm_reg == st_idle);
    assign v_o          = (fsm_reg == st_done);
    assign ciphertext_o = ct_reg;

endmodule

// File: tb/tb_aes_encryption_iter.sv
// Directed bench for aes_encryption_iter (AES-256, FIPS-197 C.3 key).
// A small inverse-cipher model is used for round-trip and zero-plaintext checks.
module tb_aes_encryption_iter;

    localparam int NR = 14;
    localparam int KW = (NR + 1) * 128;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           v_i = 1'b0;
    logic           ready_o;
    logic [127:0]   pt = '0;
    logic [KW-1:0]  kc = '0;
    logic           v_o;
    logic [127:0]   ct;
    logic           yumi = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [7:0] sbox_t [256];
    logic [7:0] inv_t  [256];
    logic [KW-1:0] key_chain;

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes_encryption_iter #(.num_rounds_p(NR)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .plaintext_i  (pt),
        .key_chain_i  (kc),
        .v_o          (v_o),
        .ciphertext_o (ct),
        .yumi_i       (yumi)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box derived algebraically: GF(2^8) inverse followed by the affine map.
    task automatic build_tables();
        logic [7:0] inv, s;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[b] = s;
            inv_t[s]  = 8'(b);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    function automatic logic [KW-1:0] expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [KW-1:0] k;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int i = 0; i < 60; i++) k[KW-1-32*i -: 32] = w[i];
        return k;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
            o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
            o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
            o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] cin, input logic [KW-1:0] k);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [127:0] s;
        s = cin ^ k[127:0];
        for (int r = NR - 1; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    t[row + 4*((col + row) % 4)] = inv_t[b[row + 4*col]];
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = t[i];
            s = s ^ k[KW-1-128*r -: 128];
            if (r > 0) s = inv_mix(s);
        end
        return s;
    endfunction

    task automatic accept(input logic [127:0] p, input logic [KW-1:0] k);
        pt = p; kc = k; v_i = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0;
    endtask

    task automatic wait_vo(output int cyc);
        cyc = 0;
        while (!v_o && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic pop();
        yumi = 1'b1;
        @(posedge clk); #1;
        yumi = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL reset_v_o got=%b exp=0", v_o); end
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        tests++; if (ct !== 128'h0) begin fails++; $display("FAIL reset_ct got=%h exp=0", ct); end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (ready_o !== 1'b1 || v_o !== 1'b0) begin fails++; $display("FAIL post_reset ready=%b v_o=%b exp 1/0", ready_o, v_o); end
        $display("[TB] reset: ready=%b v_o=%b ct=%h", ready_o, v_o, ct);
    endtask

    task automatic test_fips();
        int cyc;
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL fips_ready_pre got=%b exp=1", ready_o); end
        accept(PT1, key_chain);
        wait_vo(cyc);
        tests++; if (cyc != NR) begin fails++; $display("FAIL fips_latency got=%0d exp=%0d", cyc, NR); end
        tests++; if (ct !== CT1) begin fails++; $display("FAIL fips_ct got=%h exp=%h", ct, CT1); end
        $display("[TB] fips: pt=%h ct=%h latency=%0d", PT1, ct, cyc);
        pop();
        tests++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin fails++; $display("FAIL fips_pop v_o=%b ready=%b exp 0/1", v_o, ready_o); end
        tests++; if (ct !== CT1) begin fails++; $display("FAIL fips_ct_hold got=%h exp=%h", ct, CT1); end
    endtask

    task automatic test_round_trip();
        logic [127:0] back;
        back = aes_dec(ct, key_chain);
        tests++; if (back !== PT1) begin fails++; $display("FAIL round_trip got=%h exp=%h", back, PT1); end
        $display("[TB] round trip: ct=%h -> pt=%h", ct, back);
    endtask

    task automatic test_backpressure();
        int cyc;
        bit idle_ok;
        accept(PT1, key_chain);
        wait_vo(cyc);
        tests++; if (v_o !== 1'b1) begin fails++; $display("FAIL bp_v_o_rise got=%b exp=1 after %0d cycles", v_o, cyc); end
        for (int i = 0; i < 5; i++) begin
            v_i = (i % 2 == 0); pt = 128'h0;
            @(posedge clk); #1;
            tests++; if (v_o !== 1'b1) begin fails++; $display("FAIL bp_v_o[%0d] got=%b exp=1", i, v_o); end
            tests++; if (ct !== CT1) begin fails++; $display("FAIL bp_ct[%0d] got=%h exp=%h", i, ct, CT1); end
            tests++; if (ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, ready_o); end
        end
        v_i = 1'b0;
        pop();
        tests++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin fails++; $display("FAIL bp_pop v_o=%b ready=%b exp 0/1", v_o, ready_o); end
        idle_ok = 1'b1;
        for (int i = 0; i < NR + 2; i++) begin
            @(posedge clk); #1;
            if (v_o !== 1'b0 || ready_o !== 1'b1) idle_ok = 1'b0;
        end
        tests++; if (!idle_ok) begin fails++; $display("FAIL bp_not_queued v_o=%b ready=%b exp 0/1", v_o, ready_o); end
        $display("[TB] backpressure: ct=%h held 5 cycles", ct);
    endtask

    task automatic test_back_to_back();
        int n, nout, n1, n2;
        bit seen_ready;
        logic [127:0] c1, c2, back;
        n = 0; nout = 0; n1 = -1; n2 = -1; seen_ready = 1'b0; c1 = '0; c2 = '0;
        yumi = 1'b1;
        pt = PT1; kc = key_chain; v_i = 1'b1;
        @(posedge clk); #1;
        pt = 128'h0;
        while (nout < 2 && n < 45) begin
            @(posedge clk); #1;
            n++;
            if (v_o) begin
                if (nout == 0) begin c1 = ct; n1 = n; end
                else begin c2 = ct; n2 = n; end
                nout++;
            end
            if (nout == 1 && seen_ready && !ready_o) v_i = 1'b0;
            if (nout == 1 && ready_o) seen_ready = 1'b1;
        end
        v_i = 1'b0;
        @(posedge clk); #1;
        yumi = 1'b0;
        back = aes_dec(c2, key_chain);
        tests++; if (n1 != NR) begin fails++; $display("FAIL b2b_first_cycle got=%0d exp=%0d", n1, NR); end
        tests++; if (c1 !== CT1) begin fails++; $display("FAIL b2b_first_ct got=%h exp=%h", c1, CT1); end
        tests++; if (n2 != 2 * NR + 2) begin fails++; $display("FAIL b2b_second_cycle got=%0d exp=%0d", n2, 2 * NR + 2); end
        tests++; if (back !== 128'h0 || c2 === CT1) begin fails++; $display("FAIL b2b_second_ct ct=%h decrypts_to=%h exp_pt=0", c2, back); end
        $display("[TB] back-to-back: ct1=%h @%0d ct2=%h @%0d", c1, n1, c2, n2);
    endtask

    task automatic test_reset_mid_run();
        bit quiet;
        accept(PT1, key_chain);
        repeat (6) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL midrst_v_o got=%b exp=0", v_o); end
        tests++; if (ct !== 128'h0) begin fails++; $display("FAIL midrst_ct got=%h exp=0", ct); end
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL midrst_ready got=%b exp=1", ready_o); end
        @(negedge clk) reset_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < NR + 4; i++) begin
            @(posedge clk); #1;
            if (v_o !== 1'b0 || ready_o !== 1'b1) quiet = 1'b0;
        end
        tests++; if (!quiet) begin fails++; $display("FAIL midrst_no_pulse v_o=%b ready=%b exp 0/1", v_o, ready_o); end
        $display("[TB] reset mid-run: aborted block, ready=%b", ready_o);
        test_fips();
    endtask

    task automatic test_key_change();
        int cyc;
        accept(PT1, key_chain);
        repeat (2) @(posedge clk);
        #1;
        kc = ~key_chain;
        wait_vo(cyc);
        tests++; if (cyc + 2 != NR) begin fails++; $display("FAIL keychg_latency got=%0d exp=%0d", cyc + 2, NR); end
        tests++; if (ct !== CT1) begin fails++; $display("FAIL keychg_ct got=%h exp=%h", ct, CT1); end
        $display("[TB] key change mid-run: ct=%h", ct);
        pop();
        kc = key_chain;
    endtask

    initial begin
        build_tables();
        key_chain = expand(KEY);
        test_reset();
        test_fips();
        test_round_trip();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_key_change();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
